// File: rtl/bus_pkg.sv
// Shared definitions for the CPU memory bus: DMA state encoding and decoded address constants.
package bus_pkg;

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;

  localparam logic [15:0] HRAM_BASE = 16'hFF80;
  localparam logic [15:0] HRAM_END  = 16'hFFFE;
  localparam logic [15:0] DMA_REG   = 16'hFF46;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;

  // Sources in the echo region E0-FF fold back onto C0-DF.
  function automatic logic [7:0] src_eff(input logic [7:0] src);
    return (src >= 8'hE0) ? src - 8'h20 : src;
  endfunction

endpackage

// File: rtl/hram.sv
// 127x8 high RAM: registered write, combinational read, contents not reset.
module hram (
  input  logic       clk,
  input  logic       i_we,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [0:126];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_bus_dma.sv
// CPU bus front end: internal HRAM, external memory forwarding and optional OAM DMA engine.
// OAM DMA (FF46 register, FSM, OAM write port) is built only when OAM_DMA_EN is defined.
module mem_bus_dma
  import bus_pkg::*;
#(
  parameter int DMA_LEN         = 160,
  parameter int DMA_START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        ext_rd_en,
  output logic        ext_wr_en,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  logic        w_is_hram;
  logic        w_is_dma;
  logic        w_internal;
  logic        w_xfer;
  logic [7:0]  w_hram_rdata;
  logic [7:0]  w_dma_rdata;
  logic [15:0] w_xfer_addr;

  assign w_is_hram  = (cpu_addr >= HRAM_BASE) && (cpu_addr <= HRAM_END);
  assign w_internal = w_is_hram || w_is_dma;

  // HRAM base is 128-aligned, so the low 7 address bits index it directly.
  hram u_hram (
    .clk     (clk),
    .i_we    (cpu_wr_en && w_is_hram),
    .i_addr  (cpu_addr[6:0]),
    .i_wdata (cpu_wdata),
    .o_rdata (w_hram_rdata)
  );

`ifdef OAM_DMA_EN
  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [7:0] START_LAST = 8'(DMA_START_DELAY - 1);

  dma_state_t r_state;
  logic [7:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_src;
  logic       w_dma_wr;

  assign w_is_dma = (cpu_addr == DMA_REG);
  assign w_dma_wr = cpu_wr_en && w_is_dma;

  // A register write restarts from any state, taking priority over the XFER exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_src   <= '0;
    end else if (w_dma_wr) begin
      r_state <= START;
      r_src   <= cpu_wdata;
      r_idx   <= '0;
      r_cnt   <= START_LAST;
    end else begin
      case (r_state)
        START: begin
          if (r_cnt == '0) r_state <= XFER;
          else             r_cnt   <= r_cnt - 8'd1;
        end
        XFER: begin
          if (r_idx == LAST_IDX) begin
            r_state <= IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_xfer      = (r_state == XFER) && !rst;
  assign w_dma_rdata = r_src;
  assign w_xfer_addr = {src_eff(r_src), r_idx};
  assign dma_active  = w_xfer;
  assign oam_we      = w_xfer;
  assign oam_addr    = r_idx;
  assign oam_wdata   = ext_rdata;
`else
  logic w_unused;

  assign w_unused    = (DMA_LEN + DMA_START_DELAY) != 0;
  assign w_is_dma    = 1'b0;
  assign w_xfer      = 1'b0;
  assign w_dma_rdata = 8'hFF;
  assign w_xfer_addr = '0;
  assign dma_active  = 1'b0;
  assign oam_we      = 1'b0;
  assign oam_addr    = '0;
  assign oam_wdata   = '0;
`endif

  always_comb begin
    ext_addr  = cpu_addr;
    ext_wdata = cpu_wdata;
    ext_rd_en = 1'b0;
    ext_wr_en = 1'b0;
    if (!rst) begin
      if (w_xfer) begin
        ext_addr  = w_xfer_addr;
        ext_rd_en = 1'b1;
      end else if (!w_internal) begin
        ext_rd_en = cpu_rd_en;
        ext_wr_en = cpu_wr_en;
      end
    end
  end

  // During XFER only HRAM stays visible to the CPU.
  always_comb begin
    cpu_rdata = 8'hFF;
    if (!rst && cpu_rd_en) begin
      if (w_is_hram)    cpu_rdata = w_hram_rdata;
      else if (!w_xfer) cpu_rdata = w_is_dma ? w_dma_rdata : ext_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_dma.sv
// Randomized bench for mem_bus_dma against a cycle-indexed reference model of the bus and DMA window.
module tb_mem_bus_dma;

  localparam int L = 160;
  localparam int D = 1;
`ifdef OAM_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd_en, cpu_wr_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        ext_rd_en, ext_wr_en;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr, oam_wdata;
  logic        dma_active;

  always #5 clk = ~clk;

  mem_bus_dma #(.DMA_LEN(L), .DMA_START_DELAY(D)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ext_rd_en(ext_rd_en), .ext_wr_en(ext_wr_en), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .dma_active(dma_active)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int dma_t = -1;          // cycle of the FF46 write that started the current DMA
  logic [7:0] m_reg = 8'h00;
  logic [7:0] m_hram [127];
  bit         m_hv   [127];

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  task automatic cyc(input bit r, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] ed);
    bit is_h, is_d, x, known;
    int i, hidx;
    logic [7:0] s, exp_rd;
    @(negedge clk);
    rst = r; cpu_rd_en = rd; cpu_wr_en = wr; cpu_addr = a; cpu_wdata = wd; ext_rdata = ed;
    #1;
    is_h = (a >= 16'hFF80) && (a <= 16'hFFFE);
    is_d = DMA_EN && (a == 16'hFF46);
    hidx = int'(a) - 'hFF80;
    i = cyc_n - (dma_t + D + 1);
    x = !r && (dma_t >= 0) && (i >= 0) && (i < L);
    s = (m_reg >= 8'hE0) ? m_reg - 8'h20 : m_reg;
    chk("dma_active", 16'(dma_active), 16'(x));
    chk("oam_we", 16'(oam_we), 16'(x));
    if (x) begin
      chk("oam_addr", 16'(oam_addr), 16'(i[7:0]));
      chk("oam_wdata", 16'(oam_wdata), 16'(ed));
      chk("ext_addr_dma", ext_addr, {s, i[7:0]});
      chk("ext_rd_dma", 16'(ext_rd_en), 16'd1);
      chk("ext_wr_dma", 16'(ext_wr_en), 16'd0);
    end else begin
      chk("ext_rd_en", 16'(ext_rd_en), 16'(!r && rd && !is_h && !is_d));
      chk("ext_wr_en", 16'(ext_wr_en), 16'(!r && wr && !is_h && !is_d));
      if (!r && (rd || wr) && !is_h && !is_d) chk("ext_addr", ext_addr, a);
      if (!r && wr && !is_h && !is_d) chk("ext_wdata", 16'(ext_wdata), 16'(wd));
    end
    exp_rd = 8'hFF;
    known = 1'b1;
    if (!r && rd) begin
      if (is_h) begin
        exp_rd = m_hram[hidx];
        known  = m_hv[hidx];
      end else if (x)    exp_rd = 8'hFF;
      else if (is_d)     exp_rd = m_reg;
      else               exp_rd = ed;
    end
    if (known) chk("cpu_rdata", 16'(cpu_rdata), 16'(exp_rd));
    @(posedge clk);
    if (wr && is_h) begin
      m_hram[hidx] = wd;
      m_hv[hidx]   = 1'b1;
    end
    if (r) begin
      dma_t = -1;
      m_reg = 8'h00;
    end else if (wr && is_d) begin
      m_reg = wd;
      dma_t = cyc_n;
    end
    cyc_n++;
  endtask

  task automatic rnd_cyc(input bit allow_ctl);
    logic [15:0] a;
    bit r, rd, wr;
    case ($urandom_range(0, 7))
      0, 1, 2: a = 16'($urandom_range(0, 'hFEFF));
      3, 4:    a = 16'hFF80 + 16'($urandom_range(0, 126));
      5:       a = 16'hFF00 + 16'($urandom_range(0, 127));
      6:       a = 16'hFFFF;
      default: a = 16'hFF46;
    endcase
    r  = allow_ctl && ($urandom_range(0, 199) == 0);
    rd = $urandom_range(0, 1) == 1;
    wr = $urandom_range(0, 2) == 0;
    if (a == 16'hFF46 && wr && !(allow_ctl && $urandom_range(0, 39) == 0)) wr = 1'b0;
    cyc(r, rd, wr, a, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    rst = 1'b1; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; ext_rdata = '0;
    for (int k = 0; k < 127; k++) m_hv[k] = 1'b0;

    repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'($urandom), 8'($urandom), 8'($urandom));

    // HRAM and external read basics
    cyc(0, 0, 1, 16'hFF80, 8'h5A, 8'h00);
    cyc(0, 1, 0, 16'hFF80, 8'h00, 8'hA5);
    cyc(0, 1, 0, 16'hC000, 8'h00, 8'h3C);
    cyc(0, 1, 0, 16'hFF46, 8'h00, 8'h77);

    // Full DMA from C1 with CPU traffic and an HRAM write/read inside XFER
    cyc(0, 0, 1, 16'hFF46, 8'hC1, 8'h00);
    for (int k = 0; k < D + L + 3; k++) begin
      if (k == 20)      cyc(0, 0, 1, 16'hFF81, 8'h11, 8'($urandom));
      else if (k == 21) cyc(0, 1, 0, 16'hFF81, 8'h00, 8'($urandom));
      else if (k == 22) cyc(0, 1, 0, 16'hC000, 8'h00, 8'($urandom));
      else if (k == 23) cyc(0, 0, 1, 16'hC000, 8'h99, 8'($urandom));
      else              rnd_cyc(1'b0);
    end
    cyc(0, 1, 0, 16'hFF46, 8'h00, 8'h00);

    // Echo-region source
    cyc(0, 0, 1, 16'hFF46, 8'hFE, 8'h00);
    repeat (6) rnd_cyc(1'b0);

    // Restart on the last transfer
    cyc(0, 0, 1, 16'hFF46, 8'hC1, 8'h00);
    repeat (D + L - 1) rnd_cyc(1'b0);
    cyc(0, 0, 1, 16'hFF46, 8'h42, 8'h00);
    repeat (6) rnd_cyc(1'b0);

    // Reset in the middle of a transfer
    cyc(0, 0, 1, 16'hFF46, 8'h80, 8'h00);
    repeat (D + 50) rnd_cyc(1'b0);
    cyc(1, 1, 0, 16'hC000, 8'h00, 8'h12);
    cyc(0, 1, 0, 16'hFF46, 8'h00, 8'h34);
    repeat (3) rnd_cyc(1'b0);

    // Free-running random traffic, including restarts and resets
    repeat (3000) rnd_cyc(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_dma.md
MEM_BUS_DMA -- requirements
Module: mem_bus_dma

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, bytes copied per OAM DMA.
REQ-002 SHALL have parameter DMA_START_DELAY, default 1, cycles from FF46 write to first transfer.
REQ-003 SHALL have port clk input 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-005 SHALL have ports cpu_rd_en, cpu_wr_en input 1 each, cpu_addr input 16 and cpu_wdata input 8: CPU bus request.
REQ-006 SHALL have port cpu_rdata output 8: read data, combinational, valid in the same cycle as cpu_rd_en.
REQ-007 SHALL have ports ext_rd_en, ext_wr_en output 1 each, ext_addr output 16 and ext_wdata output 8: external memory request.
REQ-008 SHALL have port ext_rdata input 8: external read data, asynchronous (same-cycle).
REQ-009 SHALL have ports oam_we output 1, oam_addr output 8 and oam_wdata output 8: OAM write port.
REQ-010 SHALL have port dma_active output 1: high while in XFER.

Function
REQ-011 SHALL decode FF80-FFFE as internal HRAM (127x8): write registered on cpu_wr_en, read combinational.
REQ-012 SHALL decode FF46 as DMA register: write loads src and starts DMA; read returns last written value.
REQ-013 SHALL NOT forward internal addresses (HRAM, FF46) to ext_*; ext_rd_en/ext_wr_en stay 0 for them.
REQ-014 SHALL, outside XFER, drive ext_addr=cpu_addr, ext_wdata=cpu_wdata, ext_rd_en=cpu_rd_en, ext_wr_en=cpu_wr_en for non-internal addresses.
REQ-015 SHALL drive cpu_rdata: HRAM data, FF46 value, else ext_rdata; 8'hFF when cpu_rd_en=0.
REQ-016 SHALL implement FSM IDLE -> START (DMA_START_DELAY cycles) -> XFER (DMA_LEN cycles) -> IDLE.
REQ-017 SHALL, in XFER with index i (0..DMA_LEN-1), drive ext_addr={src_eff,i[7:0]}, ext_rd_en=1, ext_wr_en=0, oam_we=1, oam_addr=i, oam_wdata=ext_rdata; i increments each cycle.
REQ-018 SHALL map src E0-FF to src_eff=src-8'h20; otherwise src_eff=src.
REQ-019 SHALL, in XFER, block CPU non-HRAM accesses: reads return 8'hFF, writes dropped; HRAM access unaffected.
REQ-020 SHALL, on FF46 write in START or XFER, restart: load new src, i=0, enter START; restart wins over the last-transfer exit to IDLE.
REQ-021 SHALL, after i=DMA_LEN-1, enter IDLE next cycle; dma_active falls the same cycle.
REQ-022 SHALL keep oam_we=0 outside XFER.

Reset
REQ-023 SHALL, while rst=1, force FSM=IDLE, i=0, FF46 register=8'h00, and drive ext_rd_en=ext_wr_en=oam_we=dma_active=0, cpu_rdata=8'hFF.
REQ-024 SHALL abort any DMA in progress when rst asserts; no OAM write in the rst cycle.
REQ-025 SHALL leave HRAM contents unreset.

Configuration
REQ-026 SHALL compile DMA logic only when macro OAM_DMA_EN is defined.
REQ-027 SHALL, without OAM_DMA_EN, treat FF46 as an ordinary external address, tie oam_we, oam_addr, oam_wdata and dma_active to 0, and omit the FSM.

Structure
REQ-028 SHALL place dma_state_t (IDLE, START, XFER) and address constants (HRAM_BASE 16'hFF80, HRAM_END 16'hFFFE, DMA_REG 16'hFF46, OAM_BASE 16'hFE00) in shared package bus_pkg.
REQ-029 SHALL instantiate a sub-module hram (127x8, sync write, async read).

Verification
REQ-030 SHALL cover: write FF80=8'h5A, read FF80 -> cpu_rdata=8'h5A, ext_rd_en=0.
REQ-031 SHALL cover: ext_rdata=8'h3C, read C000 -> ext_addr=C000, ext_rd_en=1, cpu_rdata=8'h3C.
REQ-032 SHALL cover: write FF46=8'hC1 -> after 1 cycle dma_active=1 for exactly 160 cycles; oam_addr 00..9F with ext_addr C100..C19F.
REQ-033 SHALL cover: during XFER, read C000 -> 8'hFF; write FF81=8'h11 then read -> 8'h11.
REQ-034 SHALL cover: write FF46=8'hFE -> ext_addr starts DE00.
REQ-035 SHALL cover: FF46 rewrite at i=159 -> restart at i=0 from new src; rst at i=50 -> dma_active=0 and oam_we=0 next cycle.
